// File: rtl/xor_result_collector_pkg.sv
// Shared result-bus definitions for the XOR stage, its collector and the bench scoreboard.
`default_nettype none

package xor_result_collector_pkg;

  localparam int RES_W = 2;

  typedef logic [RES_W-1:0] res_t;

  localparam res_t RES_ZERO = 2'b00;
  localparam res_t RES_ONE  = 2'b01;

  function automatic logic is_one(input res_t r);
    return (r == RES_ONE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/xrc_fifo.sv
// Generic show-ahead FIFO: the head entry is presented combinationally, no read latency.
`default_nettype none

module xrc_fifo
  import xor_result_collector_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = RES_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     push_ok
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             pop_ok;

  assign full   = (level_q == LVL_W'(DEPTH));
  assign empty  = (level_q == '0);
  assign pop_ok = pop & ~empty;
  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);

  assign level     = level_q;
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/xor_result_collector.sv
// Samples upstream XOR results on a delayed strobe, buffers them, and tracks
// a sticky overflow flag plus a running count of results equal to one.
`default_nettype none

module xor_result_collector
  import xor_result_collector_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int SAMPLE_LAG = 1,
  parameter int CNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en_in,
  input  logic [RES_W-1:0]       dout_in,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [RES_W-1:0]       m_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  input  logic                   clr_ovf,
  output logic [CNT_W-1:0]       ones_cnt
);

  logic             cap;
  logic             pop;
  logic             push_ok;
  logic             drop;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] ones_cnt_q, ones_cnt_d;

  generate
    if (SAMPLE_LAG == 0) begin : g_lag_none
      assign cap = rd_en_in;
    end else begin : g_lag_pipe
      logic [SAMPLE_LAG-1:0] lag_q, lag_d;

      always_comb begin
        lag_d = (lag_q << 1) | SAMPLE_LAG'(rd_en_in);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lag_q <= '0;
        end else begin
          lag_q <= lag_d;
        end
      end

      assign cap = lag_q[SAMPLE_LAG-1];
    end
  endgenerate

  assign m_valid = ~empty;
  assign pop     = m_valid & m_ready;

  xrc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RES_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cap),
    .push_data (dout_in),
    .pop       (pop),
    .head_data (m_data),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .push_ok   (push_ok)
  );

  assign drop = cap & ~push_ok;

  // A drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
    ones_cnt_d = ones_cnt_q;
    if (push_ok && is_one(dout_in)) begin
      ones_cnt_d = ones_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      ones_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      ones_cnt_q <= ones_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign ones_cnt = ones_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_xor_result_collector.sv
// Self-checking bench: directed vector table, reset/wrap sequences and a random
// stream, all compared against a queue-based reference model.
`default_nettype none

module tb_xor_result_collector;

  localparam int DEPTH      = 4;
  localparam int SAMPLE_LAG = 1;
  localparam int CNT_W      = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd_en_in;
  logic [1:0] dout_in;
  logic       m_valid;
  logic       m_ready;
  logic [1:0] m_data;
  logic [2:0] level;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       clr_ovf;
  logic [7:0] ones_cnt;

  xor_result_collector #(
    .DEPTH      (DEPTH),
    .SAMPLE_LAG (SAMPLE_LAG),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_en_in (rd_en_in),
    .dout_in  (dout_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .clr_ovf  (clr_ovf),
    .ones_cnt (ones_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [1:0] mq[$];
  bit         hist[$];
  bit         m_ovf;
  int         m_ones;

  typedef struct {
    logic       rd;
    logic [1:0] d;
    logic       mr;
    logic       clr;
    logic       ev;
    logic [1:0] edata;
    int         elvl;
    logic       eovf;
    int         eones;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    hist.delete();
    repeat (SAMPLE_LAG) hist.push_back(1'b0);
    m_ovf  = 1'b0;
    m_ones = 0;
  endtask

  task automatic model_step(input logic r, input logic [1:0] d, input logic mr, input logic c);
    bit cap, do_pop, ok;
    hist.push_back(r);
    cap    = hist.pop_front();
    do_pop = (mq.size() > 0) && mr;
    ok     = cap && ((mq.size() < DEPTH) || do_pop);
    if (do_pop) void'(mq.pop_front());
    if (ok) begin
      mq.push_back(d);
      if (d == 2'b01) m_ones = (m_ones + 1) % (1 << CNT_W);
    end
    if (cap && !ok) m_ovf = 1'b1;
    else if (c)     m_ovf = 1'b0;
  endtask

  task automatic compare_model();
    check("m_valid",  int'(m_valid),  int'(mq.size() > 0));
    check("m_data",   int'(m_data),   (mq.size() > 0) ? int'(mq[0]) : 0);
    check("level",    int'(level),    mq.size());
    check("full",     int'(full),     int'(mq.size() == DEPTH));
    check("empty",    int'(empty),    int'(mq.size() == 0));
    check("overflow", int'(overflow), int'(m_ovf));
    check("ones_cnt", int'(ones_cnt), m_ones);
  endtask

  task automatic cycle(input logic r, input logic [1:0] d, input logic mr, input logic c);
    rd_en_in = r;
    dout_in  = d;
    m_ready  = mr;
    clr_ovf  = c;
    model_step(r, d, mr, c);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic add(input logic rd, input logic [1:0] d, input logic mr, input logic clr,
                     input logic ev, input logic [1:0] edata, input int elvl,
                     input logic eovf, input int eones);
    vec_t v;
    v.rd = rd; v.d = d; v.mr = mr; v.clr = clr;
    v.ev = ev; v.edata = edata; v.elvl = elvl; v.eovf = eovf; v.eones = eones;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; rd_en_in = 1'b0; dout_in = 2'b00; m_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", int'(m_valid), 0);
    check("rst_data",  int'(m_data),  0);
    check("rst_empty", int'(empty),   1);
    check("rst_full",  int'(full),    0);
    check("rst_ones",  int'(ones_cnt), 0);
    rst = 1'b0;

    // single result, fill, overflow, full push/pop, backpressure, clear, clear-vs-drop
    add(1,0,1,0, 0,0,0,0,0);
    add(0,1,1,0, 1,1,1,0,1);
    add(0,0,1,0, 0,0,0,0,1);
    add(1,0,0,0, 0,0,0,0,1);
    add(1,1,0,0, 1,1,1,0,2);
    add(1,0,0,0, 1,1,2,0,2);
    add(1,1,0,0, 1,1,3,0,3);
    add(1,1,0,0, 1,1,4,0,4);
    add(0,1,0,0, 1,1,4,1,4);
    add(1,0,0,0, 1,1,4,1,4);
    add(0,0,1,0, 1,0,4,1,4);
    repeat (5) add(0,0,0,0, 1,0,4,1,4);
    add(0,0,0,1, 1,0,4,0,4);
    add(0,0,0,0, 1,0,4,0,4);
    add(0,0,1,0, 1,1,3,0,4);
    add(0,0,1,0, 1,1,2,0,4);
    add(0,0,1,0, 1,0,1,0,4);
    add(0,0,1,0, 0,0,0,0,4);
    add(1,0,0,0, 0,0,0,0,4);
    add(1,0,0,0, 1,0,1,0,4);
    add(1,1,0,0, 1,0,2,0,5);
    add(1,0,0,0, 1,0,3,0,5);
    add(1,1,0,0, 1,0,4,0,6);
    add(0,1,0,1, 1,0,4,1,6);
    add(0,0,0,1, 1,0,4,0,6);
    add(0,0,1,0, 1,1,3,0,6);
    add(0,0,1,0, 1,0,2,0,6);

    foreach (vecs[i]) begin
      cycle(vecs[i].rd, vecs[i].d, vecs[i].mr, vecs[i].clr);
      check($sformatf("vec%0d_valid", i), int'(m_valid),  int'(vecs[i].ev));
      check($sformatf("vec%0d_data", i),  int'(m_data),   int'(vecs[i].edata));
      check($sformatf("vec%0d_level", i), int'(level),    vecs[i].elvl);
      check($sformatf("vec%0d_ovf", i),   int'(overflow), int'(vecs[i].eovf));
      check($sformatf("vec%0d_ones", i),  int'(ones_cnt), vecs[i].eones);
    end

    // Asynchronous reset mid-stream with two entries queued and a strobe in flight
    cycle(1, 2'b01, 0, 0);
    #1 rst = 1'b1;
    #1;
    check("arst_level", int'(level),    0);
    check("arst_valid", int'(m_valid),  0);
    check("arst_data",  int'(m_data),   0);
    check("arst_ones",  int'(ones_cnt), 0);
    check("arst_ovf",   int'(overflow), 0);
    model_reset();
    rd_en_in = 1'b0;
    #2 rst = 1'b0;
    cycle(0, 2'b01, 1, 0);
    check("arst_inflight_level", int'(level), 0);

    // 300 results of one streamed through: pointer wrap and counter wrap
    for (int i = 0; i <= 300; i++) cycle(i < 300, 2'b01, 1, 0);
    repeat (3) cycle(0, 2'b00, 1, 0);
    check("wrap_ones", int'(ones_cnt), 300 % 256);
    check("wrap_ovf",  int'(overflow), 0);
    check("wrap_empty", int'(empty), 1);

    // Random traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)),
            $urandom_range(0, 9) < 5, $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/xor_result_collector.md
Name: xor_result_collector

Overview:
Downstream stage of the registered XOR unit. Samples the 2-bit result bus when the upstream read strobe says it is valid, and buffers results in a small show-ahead FIFO. Presents buffered results to the consumer over a valid/ready interface. Keeps a sticky overflow flag and a running count of results with value 1.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
SAMPLE_LAG, 1, cycles between rd_en_in high and the cycle dout_in is sampled; range 0..3.
CNT_W, 8, width of ones_cnt.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
rd_en_in  input  1  result strobe from upstream XOR stage (one cycle per result)
dout_in  input  2  upstream result bus; bit 0 = XOR result, bit 1 always 0
m_valid  output  1  FIFO head holds a result
m_ready  input  1  consumer accepts head this cycle
m_data  output  2  FIFO head entry; 2'b00 when empty
level  output  $clog2(DEPTH)+1  current occupancy 0..DEPTH
full  output  1  level == DEPTH
empty  output  1  level == 0
overflow  output  1  sticky; a result was dropped
clr_ovf  input  1  synchronous clear of overflow
ones_cnt  output  CNT_W  count of accepted results equal to 2'b01

Behaviour:
- Reset (async, rst high): FIFO pointers, level, ones_cnt, overflow and strobe delay line all 0.
  - m_valid=0, m_data=2'b00, empty=1, full=0.
  - Entries pending in the delay line are discarded; deassertion gives a clean empty FIFO.
- Capture strobe cap = rd_en_in delayed by SAMPLE_LAG registers.
  - SAMPLE_LAG=0 means cap = rd_en_in combinationally.
  - dout_in is sampled in the cycle cap is high.
- push = cap. pop = m_valid & m_ready.
- Show-ahead FIFO: m_data = mem[rd_ptr] while not empty, with no read latency. A pushed entry is visible on m_data the cycle after the push edge.
- Pointers wrap modulo DEPTH. level = level + push_ok - pop.
- Push when not full: write mem[wr_ptr], advance wr_ptr.
- Push when full and pop in the same cycle: both happen, level unchanged, no overflow.
- Push when full without pop: entry dropped, pointers unchanged, overflow set to 1 next edge.
- Pop when empty cannot occur, because m_valid=0. m_ready is ignored while empty.
- overflow stays high until clr_ovf. If clr_ovf and a new drop occur in the same cycle, the drop wins and overflow stays 1.
- ones_cnt increments on each successful push with dout_in==2'b01.
  - Wraps modulo 2^CNT_W.
  - Dropped entries are not counted.
- Entries with dout_in[1]=1 are stored as received; no checking.
- Latency from rd_en_in to m_valid: SAMPLE_LAG+1 cycles when the FIFO is empty.
- m_data stays stable while m_valid=1 and m_ready=0.

Decomposition:
- Shared package:
  - RES_W=2 (result width).
  - Result encoding constants RES_ZERO=2'b00 and RES_ONE=2'b01, also used by the XOR stage and the bench scoreboard.
- One natural sub-module: xrc_fifo, a generic show-ahead FIFO (DEPTH, width RES_W) with push/pop/level/full/empty.
- The delay line, overflow flag and counter stay in the top.

Test Plan:
1. Reset/idle:
   - Stimulus: assert rst mid-stream with 2 entries queued and a strobe in flight.
   - Response: next cycle level=0, m_valid=0, m_data=00, ones_cnt=0, overflow=0; the in-flight strobe produces no push.
2. Single result, SAMPLE_LAG=1, m_ready=1:
   - Stimulus: rd_en_in at cycle 0, dout_in=01 at cycle 1.
   - Response: m_valid=1 with m_data=01 at cycle 2, popped at cycle 2, ones_cnt=1.
3. Fill, DEPTH=4, m_ready=0:
   - Stimulus: push 01,00,01,01.
   - Response: full=1, level=4, ones_cnt=3. Then a fifth push of 01: overflow=1, level=4, ones_cnt=3, head still 01.
4. Full with simultaneous push/pop:
   - Stimulus: with full=1, push 00 while m_ready=1.
   - Response: level stays 4, no overflow. Drain order is 00,01,01,00 relative to the entries queued in scenario 3 after its first pop.
5. Backpressure stability:
   - Stimulus: m_ready=0 for 5 cycles with m_valid=1.
   - Response: m_data unchanged throughout. Then clr_ovf=1 for one cycle, after which overflow=0.
6. Wrap and counter:
   - Stimulus: stream 300 results of 01 through the FIFO with m_ready=1 (CNT_W=8).
   - Response: no overflow, every output equals 01, ones_cnt=300 mod 256 = 44.
